// File: rtl/dotmatrix_pkg.sv
// Shared types for the 16x16 dot-matrix display path (display controller and scan driver).
package dotmatrix_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int RW   = $clog2(ROWS);

  typedef logic [ROWS-1:0]      row_t;
  typedef logic [COLS-1:0]      col_t;
  typedef logic [ROWS*COLS-1:0] frame_t;
  typedef logic [RW-1:0]        row_idx_t;

  localparam col_t COL_OFF = '1;

  // Row r of a frame is the 16-bit slice starting at bit r*COLS; bit c is column c.
  function automatic col_t row_slice(input frame_t f, input row_idx_t r);
    return f[int'(r)*COLS +: COLS];
  endfunction

endpackage

// File: rtl/dotmatrix_slot_timer.sv
// Slot timer: cycle counter within a row slot and the row index, with slot/frame strobes.
// Exposes next-state values so the top can register outputs that match the new slot position.
module dotmatrix_slot_timer
  import dotmatrix_pkg::*;
#(
  parameter int ROW_CYCLES = 1024,
  parameter int CW         = $clog2(ROW_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] cnt_d_o,
  output row_idx_t      r_d_o,
  output logic          slot_end_o,
  output logic          frame_wrap_o
);

  localparam logic [CW-1:0] LAST_CNT = CW'(ROW_CYCLES - 1);
  localparam row_idx_t      LAST_ROW = RW'(ROWS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  row_idx_t      r_q, r_d;
  logic          slot_end, frame_wrap;

  always_comb begin
    slot_end   = (cnt_q == LAST_CNT);
    frame_wrap = slot_end && (r_q == LAST_ROW);
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    r_d        = slot_end ? r_q + 1'b1 : r_q;
  end

  // Reset parks on the last cycle of row 15 so the first edge after release is a frame boundary.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= LAST_CNT;
      r_q   <= LAST_ROW;
    end else begin
      cnt_q <= cnt_d;
      r_q   <= r_d;
    end
  end

  assign cnt_d_o      = cnt_d;
  assign r_d_o        = r_d;
  assign slot_end_o   = slot_end;
  assign frame_wrap_o = frame_wrap;

endmodule

// File: rtl/dotmatrix_scan.sv
// Row-multiplexed scan driver: latches a frame at each frame boundary, blanks the start of every row slot.
// Optional brightness control with `define DOTMAT_DIM_EN (adds the dim port).
module dotmatrix_scan
  import dotmatrix_pkg::*;
#(
  parameter int ROW_CYCLES = 1024,
  parameter int BLANK      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  frame_t     pattern,
`ifdef DOTMAT_DIM_EN
  input  logic [2:0] dim,
`endif
  output row_t       row,
  output col_t       col_n,
  output logic       frame_start
);

  localparam int            CW      = $clog2(ROW_CYCLES);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt_d;
  row_idx_t      r_d;
  logic          slot_end, frame_wrap;

  dotmatrix_slot_timer #(
    .ROW_CYCLES (ROW_CYCLES),
    .CW         (CW)
  ) u_slot_timer (
    .clk          (clk),
    .reset        (reset),
    .cnt_d_o      (cnt_d),
    .r_d_o        (r_d),
    .slot_end_o   (slot_end),
    .frame_wrap_o (frame_wrap)
  );

  frame_t frame_buf_q, frame_buf_d;
  row_t   ring_q, ring_d;
  row_t   row_q, row_d;
  col_t   col_n_q, col_n_d;
  logic   frame_start_q, frame_start_d;
  logic   drive_cols;

`ifdef DOTMAT_DIM_EN
  localparam int LIT     = ROW_CYCLES - BLANK;
  localparam int SUB_LEN = LIT / 8;

  if (LIT % 8 != 0) begin : g_bad_lit
    $error("dotmatrix_scan: ROW_CYCLES-BLANK must be a multiple of 8 with DOTMAT_DIM_EN");
  end

  logic [2:0]    dim_q, dim_d;
  logic [CW-1:0] sub;

  // The lit window is split into eight equal sub-slots; columns are driven up to sub-slot dim.
  always_comb begin
    dim_d      = frame_wrap ? dim : dim_q;
    sub        = (cnt_d - BLANK_C) / CW'(SUB_LEN);
    drive_cols = (sub <= CW'(dim_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dim_q <= 3'd7;
    else        dim_q <= dim_d;
  end
`else
  assign drive_cols = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    frame_buf_d   = frame_wrap ? pattern : frame_buf_q;
    ring_d        = slot_end ? {ring_q[ROWS-2:0], ring_q[ROWS-1]} : ring_q;
    row_d         = '0;
    col_n_d       = COL_OFF;
    frame_start_d = frame_wrap;
    if (cnt_d >= BLANK_C) begin
      row_d = ring_d;
      if (drive_cols) col_n_d = ~row_slice(frame_buf_d, r_d);
    end
  end

  // Row-select ring tracks r as a one-hot; it starts on row 15 so the first slot lands on row 0.
  // NOTE: frame_buf is a plain register bank, so it can take an async reset to a defined dark frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_buf_q   <= '0;
      ring_q        <= row_t'(1) << (ROWS - 1);
      row_q         <= '0;
      col_n_q       <= COL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      frame_buf_q   <= frame_buf_d;
      ring_q        <= ring_d;
      row_q         <= row_d;
      col_n_q       <= col_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row         = row_q;
  assign col_n       = col_n_q;
  assign frame_start = frame_start_q;

endmodule
